aes_text_out_unloader: RTL and testbench
========================================

# aes_text_out_unloader

Output-side companion to `aes_cipher_top`. It captures each 128-bit `text_out` block when the cipher pulses `done`, holds captured blocks in a small FIFO, and streams them to the downstream consumer as 32-bit words under a valid/ready handshake. It decouples the cipher's one-cycle result strobe from a slower or back-pressuring sink, and it flags any result lost to a full buffer.

## Interface
- `DEPTH`, default 2: number of 128-bit blocks buffered. Must be a power of 2 and at least 2.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-low. `rst=0` resets the block immediately.
- `done` in 1: from the cipher. Single-cycle strobe; `text_out` is valid in that cycle.
- `text_out` in 128: cipher result, sampled only when `done=1`.
- `out_valid` out 1: the current word on `out_data` is valid.
- `out_ready` in 1: the sink accepts the current word.
- `out_data` out 32: current word of the head block.
- `out_last` out 1: the current word is the 4th (final) word of its block.
- `cnt` out $clog2(DEPTH+1): number of blocks held, including a partially drained head block.
- `ovf` out 1: sticky flag. Set when a `done` strobe is dropped.
- `clr_ovf` in 1: synchronous clear of `ovf`.

## Operation
- Storage: `DEPTH` × 128-bit entries, write pointer, read pointer, occupancy `cnt`, and a 2-bit word index `widx` for the head block.
- Push: happens when `done=1` and a slot is free. `text_out` is written at the write pointer; the pointer wraps modulo `DEPTH`.
- Pop: a word transfer is `out_valid & out_ready`.
  - Each transfer increments `widx`.
  - A transfer with `widx==3` pops the head entry, advances the read pointer (wrapping), and returns `widx` to 0.
- `out_valid = (cnt != 0)`.
- `out_last = out_valid & (widx==3)`.
- `out_data` is a combinational select from the registered head entry. Default word order is MSW first:
  - `widx=0` → `[127:96]`
  - `widx=1` → `[95:64]`
  - `widx=2` → `[63:32]`
  - `widx=3` → `[31:0]`
- Full with simultaneous pop and `done`: if `cnt==DEPTH` and the last-word transfer happens in the same cycle as `done`, the push is accepted. `cnt` stays at `DEPTH` and `ovf` is not set.
- Full without pop: if `cnt==DEPTH`, `done=1`, and there is no last-word pop, the block is dropped. Stored contents are unchanged and `ovf` is set to 1.
- Empty with `done`: the push happens; there is no bypass.
- `ovf` priority: if `clr_ovf=1` and a new drop happen in the same cycle, the set wins (`ovf=1`).
- Backpressure: while `out_valid=1` and `out_ready=0`, `out_data`, `out_last` and `widx` hold stable.
- `text_out` is ignored whenever `done=0`.

## Timing
- Reset values:
  - `out_valid=0`, `out_last=0`, `out_data=0`, `cnt=0`, `ovf=0`.
  - Internally, both pointers and `widx` are 0; FIFO storage is cleared.
- Asserting `rst` (0) mid-operation discards all buffered and partially drained data. Outputs take their reset values without waiting for a clock edge.
- Latency: `done` sampled at edge N gives `out_valid=1` with word 0 from edge N onward, i.e. visible in cycle N+1.
- Throughput: one word per cycle while `out_ready=1`. One block drains in 4 cycles; back-to-back blocks drain with no bubble.
- `cnt` updates at the edge of the push/pop. A same-cycle push and pop leaves it unchanged.

## Configuration
- `AES_UNLOAD_LSW_FIRST_EN` defined: word order is reversed.
  - `widx=0` → `[31:0]` … `widx=3` → `[127:96]`.
  - All handshake and timing behaviour is identical.
- `AES_UNLOAD_LSW_FIRST_EN` not defined: MSW-first order as described in Operation.

## Test plan
- Reset: hold `rst=0` with `done=1` pulsing → `out_valid=0`, `cnt=0`, `ovf=0` throughout. Release `rst` → still empty.
- Single block: `done` with `text_out=128'h69c4e0d86a7b0430d8cdb78070b4c55a`, `out_ready=1`.
  - Next 4 cycles give `69c4e0d8`, `6a7b0430`, `d8cdb780`, `70b4c55a`.
  - `out_last=1` only on the 4th word; then `out_valid=0` and `cnt=0`.
- Backpressure: drop `out_ready` to 0 after word 1 for 5 cycles → `out_data=6a7b0430` stays stable and `cnt=1`. Resume → remaining words arrive in order.
- Overflow (`DEPTH=2`): three `done` pulses (keys `000102…0e0f`, `ff…ff`, `00…00` results) with `out_ready=0`.
  - Result: `cnt=2`, `ovf=1`.
  - Drain yields only the first two blocks.
  - `clr_ovf` pulse → `ovf=0`.
- Full with same-cycle pop and `done`: `cnt=2`, `out_ready=1` at `widx=3`, `done=1` in the same cycle → block accepted, `cnt=2`, `ovf=0`, 8 further words drained.
- Reset mid-drain: `rst=0` after word 2 of a block → `out_valid=0` immediately. After release, no residual words appear. A new `done` yields word 0 of the new block.

Source files
------------

// File: rtl/aes_text_out_unloader.sv
// rtl/aes_text_out_unloader.sv - buffers AES text_out blocks and streams them as 32-bit words
//
// Captures the 128-bit cipher result on each done strobe into a DEPTH-entry
// FIFO and unloads the head block one 32-bit word at a time under a
// valid/ready handshake. A done strobe that finds the FIFO full (with no
// same-cycle final-word pop) is dropped and latches the sticky ovf flag.
//
// Optional build macro: AES_UNLOAD_LSW_FIRST_EN - emit words LSW first
// instead of the default MSW-first order.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   done       cipher result strobe, text_out valid in the same cycle
//   text_out   128-bit cipher result
//   out_valid  out_data holds a valid word
//   out_ready  sink accepts the current word
//   out_data   current 32-bit word of the head block
//   out_last   current word is the final word of its block
//   cnt        number of blocks held (head counts until its last word leaves)
//   ovf        sticky dropped-block flag
//   clr_ovf    synchronous clear of ovf (a same-cycle drop wins)
module aes_text_out_unloader #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done,
  input  logic [127:0]               text_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic                       ovf,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [1:0]    widx;

  logic          xfer;
  logic          pop;
  logic          full;
  logic          push;
  logic          drop;
  logic [127:0]  head;
  logic [1:0]    sel;

  assign out_valid = (cnt != '0);
  assign out_last  = out_valid & (widx == 2'd3);
  assign xfer      = out_valid & out_ready;
  assign pop       = xfer & (widx == 2'd3);
  assign full      = (cnt == CW'(DEPTH));
  // When full, wptr equals rptr; a same-cycle final-word pop frees exactly
  // the slot being written, so the push can be accepted.
  assign push      = done & (~full | pop);
  assign drop      = done & full & ~pop;

  assign head = mem[rptr];

`ifdef AES_UNLOAD_LSW_FIRST_EN
  assign sel = widx;
`else
  assign sel = 2'd3 - widx;
`endif

  // Gated so an empty buffer shows zero rather than a stale, already-sent block.
  assign out_data = out_valid ? head[{sel, 5'b0} +: 32] : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr <= '0;
      rptr <= '0;
      widx <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= text_out;
        wptr      <= wptr + AW'(1);
      end

      if (xfer) begin
        widx <= widx + 2'd1;
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end

      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end

      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_text_out_unloader.sv
// tb/tb_aes_text_out_unloader.sv - directed self-checking bench for aes_text_out_unloader
module tb_aes_text_out_unloader;

  logic         clk;
  logic         rst;
  logic         done;
  logic [127:0] text_out;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic [1:0]   cnt;
  logic         ovf;
  logic         clr_ovf;

  int checks;
  int errors;

  localparam logic [127:0] BLK_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BLK_B = 128'h0a940bb5416ef045f1c39458c653ea5a;
  localparam logic [127:0] BLK_C = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] BLK_D = 128'h00112233445566778899aabbccddeeff;

  aes_text_out_unloader #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .text_out  (text_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .cnt       (cnt),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] blk, input int i);
`ifdef AES_UNLOAD_LSW_FIRST_EN
    return blk[32*i +: 32];
`else
    return blk[127-32*i -: 32];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumes one full block with out_ready=1, checking each word and out_last.
  task automatic drain_block(input string tag, input logic [127:0] blk);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_data"}, out_data, word_of(blk, i));
      check({tag, "_last"}, out_last, (i == 3));
      tick();
    end
  endtask

  task automatic push_block(input logic [127:0] blk);
    done     = 1'b1;
    text_out = blk;
    tick();
    done     = 1'b0;
    text_out = '0;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_last"}, out_last, 1'b0);
    check({tag, "_cnt"}, cnt, 2'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    done      = 1'b0;
    text_out  = '0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;

    // Reset held while done pulses: nothing is captured.
    for (int i = 0; i < 4; i++) begin
      done     = i[0];
      text_out = BLK_A;
      tick();
      check_empty("rst_hold");
      check("rst_hold_ovf", ovf, 1'b0);
      check("rst_hold_data", out_data, 32'h0);
    end
    done = 1'b0;
    rst  = 1'b1;
    tick();
    tick();
    check_empty("rst_rel");
    check("rst_rel_ovf", ovf, 1'b0);

    // Single block, sink always ready.
    out_ready = 1'b1;
    push_block(BLK_A);
    check("single_cnt", cnt, 2'd1);
    drain_block("single", BLK_A);
    check_empty("single_end");

    // Backpressure while word 1 is presented.
    push_block(BLK_A);
    check("bp_w0", out_data, 32'h69c4e0d8);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", out_data, 32'h6a7b0430);
      check("bp_hold_last", out_last, 1'b0);
      check("bp_hold_cnt", cnt, 2'd1);
      tick();
    end
    out_ready = 1'b1;
    check("bp_w1", out_data, 32'h6a7b0430);
    tick();
    check("bp_w2", out_data, 32'hd8cdb780);
    tick();
    check("bp_w3", out_data, 32'h70b4c55a);
    check("bp_w3_last", out_last, 1'b1);
    tick();
    check_empty("bp_end");

    // Overflow: third block dropped, set beats a same-cycle clear.
    out_ready = 1'b0;
    push_block(BLK_B);
    push_block(BLK_C);
    check("ovf_full_cnt", cnt, 2'd2);
    check("ovf_pre", ovf, 1'b0);
    push_block(BLK_D);
    check("ovf_cnt", cnt, 2'd2);
    check("ovf_set", ovf, 1'b1);
    clr_ovf = 1'b1;
    push_block(BLK_D);
    clr_ovf = 1'b0;
    check("ovf_set_wins", ovf, 1'b1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clr", ovf, 1'b0);
    drain_block("ovf_b", BLK_B);
    drain_block("ovf_c", BLK_C);
    check_empty("ovf_end");

    // Full, final-word pop coincides with done: push accepted.
    out_ready = 1'b0;
    push_block(BLK_A);
    push_block(BLK_B);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("fp_last", out_last, 1'b1);
    check("fp_cnt_pre", cnt, 2'd2);
    push_block(BLK_C);
    check("fp_cnt", cnt, 2'd2);
    check("fp_ovf", ovf, 1'b0);
    drain_block("fp_b", BLK_B);
    drain_block("fp_c", BLK_C);
    check_empty("fp_end");

    // Reset mid-drain takes effect without a clock edge.
    push_block(BLK_A);
    tick();
    tick();
    check("mid_w2", out_data, 32'hd8cdb780);
    #2;
    rst = 1'b0;
    #1;
    check_empty("mid_rst");
    check("mid_rst_data", out_data, 32'h0);
    tick();
    #2;
    rst = 1'b1;
    tick();
    tick();
    check_empty("mid_after");
    push_block(BLK_D);
    check("mid_new_cnt", cnt, 2'd1);
    drain_block("mid_new", BLK_D);
    check_empty("mid_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
